coin_accept: RTL and testbench

Coin acceptance and credit controller for the vending datapath. It edge-detects coin sensor inputs, accumulates credit in cents, and honours purchase or cancel requests. On a request it computes the change owed and hands that amount to the downstream coin-return block through a start/done handshake. It forms the intake end of the coin path: its `change`/`return_start` outputs drive the return block's coin-value and start inputs.

---
 rtl/coin_accept.sv | 142 ++++++++++++++
 tb/tb_coin_accept.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_accept.sv
// Coin intake and credit controller: edge-detects coin/select/cancel levels, accumulates credit, vends and hands change to the return block.
// Latency: one clock from a sampled input rise to the updated credit / coin_reject; purchase reaches return_start two clocks after select.
// Backpressure: none on inputs; while busy, coins are refused via coin_reject and select/cancel are dropped, and WAIT_RET holds until return_done.
//
// Ports:
//   clk, reset            system clock (rising edge), asynchronous active-high reset
//   quarter_in/dime_in/nickel_in  coin sensor levels, one coin per rising edge
//   select, cancel        purchase / refund request levels, edge-detected
//   price[7:0]            item price in cents, compared on the select rise
//   return_done           one-cycle completion pulse from the coin-return block
//   credit[7:0]           accumulated credit in cents
//   change[7:0]           amount handed to the return block, stable until back in IDLE
//   return_start          one-cycle start pulse to the return block
//   vend                  one-cycle product dispense pulse
//   coin_reject           one-cycle reject gate pulse for refused coins
//   busy                  high in every state except IDLE
module coin_accept #(
    parameter int unsigned MAX_CREDIT = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       quarter_in,
    input  logic       dime_in,
    input  logic       nickel_in,
    input  logic       select,
    input  logic       cancel,
    input  logic [7:0] price,
    input  logic       return_done,
    output logic [7:0] credit,
    output logic [7:0] change,
    output logic       return_start,
    output logic       vend,
    output logic       coin_reject,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        VEND     = 2'd1,
        START    = 2'd2,
        WAIT_RET = 2'd3
    } state_t;

    localparam logic [8:0] MAX_SUM = 9'(MAX_CREDIT);

    state_t state;

    // Previous-value registers reset high so that a level already asserted
    // when reset releases is not mistaken for a fresh coin or request.
    logic quarter_prev;
    logic dime_prev;
    logic nickel_prev;
    logic select_prev;
    logic cancel_prev;

    logic quarter_rise;
    logic dime_rise;
    logic nickel_rise;
    logic select_rise;
    logic cancel_rise;
    logic any_coin;
    logic [8:0] sum;

    always_comb begin
        quarter_rise = quarter_in & ~quarter_prev;
        dime_rise    = dime_in    & ~dime_prev;
        nickel_rise  = nickel_in  & ~nickel_prev;
        select_rise  = select     & ~select_prev;
        cancel_rise  = cancel     & ~cancel_prev;
        any_coin     = quarter_rise | dime_rise | nickel_rise;
        // 9 bits so that an overflowing batch of coins is detected rather than wrapped.
        sum = {1'b0, credit}
            + (quarter_rise ? 9'd25 : 9'd0)
            + (dime_rise    ? 9'd10 : 9'd0)
            + (nickel_rise  ? 9'd5  : 9'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            credit       <= 8'd0;
            change       <= 8'd0;
            coin_reject  <= 1'b0;
            quarter_prev <= 1'b1;
            dime_prev    <= 1'b1;
            nickel_prev  <= 1'b1;
            select_prev  <= 1'b1;
            cancel_prev  <= 1'b1;
        end else begin
            quarter_prev <= quarter_in;
            dime_prev    <= dime_in;
            nickel_prev  <= nickel_in;
            select_prev  <= select;
            cancel_prev  <= cancel;
            coin_reject  <= 1'b0;

            case (state)
                IDLE: begin
                    if (cancel_rise && (credit != 8'd0)) begin
                        change      <= credit;
                        credit      <= 8'd0;
                        state       <= START;
                        coin_reject <= any_coin;
                    end else if (select_rise && (credit >= price)) begin
                        change      <= credit - price;
                        credit      <= 8'd0;
                        state       <= VEND;
                        coin_reject <= any_coin;
                    end else if (any_coin) begin
                        // All coins of one cycle are accepted or refused as a group.
                        if (sum <= MAX_SUM) begin
                            credit <= sum[7:0];
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    coin_reject <= any_coin;
                    state       <= (change == 8'd0) ? IDLE : START;
                end
                START: begin
                    coin_reject <= any_coin;
                    state       <= WAIT_RET;
                end
                WAIT_RET: begin
                    coin_reject <= any_coin;
                    if (return_done) begin
                        state  <= IDLE;
                        change <= 8'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign vend         = (state == VEND);
    assign return_start = (state == START);
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_coin_accept.sv
// Self-checking bench for coin_accept: directed stimulus pushes the expected
// output snapshot into a queue; a negedge monitor pops and compares whenever
// the DUT outputs change or a pulse output is high.
module tb_coin_accept;

    logic       clk;
    logic       reset;
    logic       quarter_in;
    logic       dime_in;
    logic       nickel_in;
    logic       select;
    logic       cancel;
    logic [7:0] price;
    logic       return_done;
    logic [7:0] credit;
    logic [7:0] change;
    logic       return_start;
    logic       vend;
    logic       coin_reject;
    logic       busy;

    coin_accept #(.MAX_CREDIT(200)) dut (
        .clk          (clk),
        .reset        (reset),
        .quarter_in   (quarter_in),
        .dime_in      (dime_in),
        .nickel_in    (nickel_in),
        .select       (select),
        .cancel       (cancel),
        .price        (price),
        .return_done  (return_done),
        .credit       (credit),
        .change       (change),
        .return_start (return_start),
        .vend         (vend),
        .coin_reject  (coin_reject),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       vend;
        logic       rs;
        logic       cr;
        logic       busy;
        logic [7:0] credit;
        logic [7:0] change;
    } obs_t;

    obs_t exp_q[$];
    obs_t last_obs;
    int   checks   = 0;
    int   failures = 0;
    int   ev_num   = 0;
    logic mon_en   = 1'b0;

    function automatic obs_t mk(input logic v, input logic rs, input logic cr,
                                input logic b, input logic [7:0] cred,
                                input logic [7:0] chg);
        obs_t o;
        o.vend   = v;
        o.rs     = rs;
        o.cr     = cr;
        o.busy   = b;
        o.credit = cred;
        o.change = chg;
        return o;
    endfunction

    task automatic push(input obs_t o);
        exp_q.push_back(o);
    endtask

    // Monitor: an output event is any change of the observed tuple or any
    // active pulse; each event must match the next queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            obs_t cur;
            obs_t e;
            cur = mk(vend, return_start, coin_reject, busy, credit, change);
            if ((cur !== last_obs) || cur.vend || cur.rs || cur.cr) begin
                checks++;
                ev_num++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event%0d got vend=%0b rs=%0b rej=%0b busy=%0b credit=%0d change=%0d",
                             ev_num, cur.vend, cur.rs, cur.cr, cur.busy, cur.credit, cur.change);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        failures++;
                        $display("FAIL event%0d got vend=%0b rs=%0b rej=%0b busy=%0b credit=%0d change=%0d want vend=%0b rs=%0b rej=%0b busy=%0b credit=%0d change=%0d",
                                 ev_num, cur.vend, cur.rs, cur.cr, cur.busy, cur.credit, cur.change,
                                 e.vend, e.rs, e.cr, e.busy, e.credit, e.change);
                    end
                end
            end
            last_obs = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // One coin pulse (high one clock, low one clock); expected credit after it.
    task automatic coin(input logic q, input logic d, input logic n, input logic [7:0] exp_credit);
        push(mk(1'b0, 1'b0, 1'b0, 1'b0, exp_credit, 8'd0));
        quarter_in = q; dime_in = d; nickel_in = n;
        tick();
        quarter_in = 1'b0; dime_in = 1'b0; nickel_in = 1'b0;
        tick();
    endtask

    task automatic press_select(input logic [7:0] p);
        price  = p;
        select = 1'b1;
        tick();
        select = 1'b0;
        tick();
    endtask

    task automatic press_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tick();
    endtask

    task automatic finish_return();
        push(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
        return_done = 1'b1;
        tick();
        return_done = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        quarter_in = 1'b0; dime_in = 1'b0; nickel_in = 1'b0;
        select = 1'b0; cancel = 1'b0; price = 8'd0; return_done = 1'b0;
        last_obs = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        tick(); tick();

        // Reset state
        check_val("rst_credit", credit, 8'd0);
        check_val("rst_change", change, 8'd0);
        check_val("rst_vend", {7'd0, vend}, 8'd0);
        check_val("rst_return_start", {7'd0, return_start}, 8'd0);
        check_val("rst_coin_reject", {7'd0, coin_reject}, 8'd0);
        check_val("rst_busy", {7'd0, busy}, 8'd0);

        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // Credit accumulation on separate cycles
        coin(1'b1, 1'b0, 1'b0, 8'd25);
        coin(1'b0, 1'b1, 1'b0, 8'd35);
        coin(1'b0, 1'b0, 1'b1, 8'd40);

        // Exact purchase: vend once, no return_start, IDLE two clocks later
        push(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0));
        push(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
        press_select(8'd40);
        tick(); tick();

        // Purchase with change 25
        coin(1'b1, 1'b0, 1'b0, 8'd25);
        coin(1'b1, 1'b0, 1'b0, 8'd50);
        coin(1'b1, 1'b0, 1'b0, 8'd75);
        push(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd25));
        push(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd25));
        push(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd25));
        press_select(8'd50);
        tick(); tick(); tick();
        // Coin while waiting for the return block is refused
        push(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd25));
        push(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd25));
        dime_in = 1'b1;
        tick();
        dime_in = 1'b0;
        tick();
        // Select while busy (price 0 would otherwise succeed) is ignored
        press_select(8'd0);
        tick(); tick();
        finish_return();
        tick();

        // Overflow at MAX_CREDIT = 200
        for (int i = 1; i <= 7; i++) coin(1'b1, 1'b0, 1'b0, 8'(25 * i));
        coin(1'b0, 1'b1, 1'b0, 8'd185);
        coin(1'b0, 1'b0, 1'b1, 8'd190);
        push(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd190, 8'd0));
        coin(1'b1, 1'b0, 1'b0, 8'd190);
        coin(1'b0, 1'b0, 1'b1, 8'd195);
        push(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd195));
        push(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd195));
        press_cancel();
        tick();
        finish_return();
        tick();

        // Simultaneous coins, then cancel together with a dime
        coin(1'b1, 1'b1, 1'b1, 8'd40);
        coin(1'b0, 1'b1, 1'b0, 8'd50);
        coin(1'b0, 1'b1, 1'b0, 8'd60);
        push(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 8'd60));
        push(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd60));
        cancel = 1'b1; dime_in = 1'b1;
        tick();
        cancel = 1'b0; dime_in = 1'b0;
        tick();
        tick();
        finish_return();
        tick();

        // Cancel with no credit is ignored
        press_cancel();
        tick();

        // Reset while in WAIT_RET, quarter held high across release
        coin(1'b1, 1'b0, 1'b0, 8'd25);
        push(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd25));
        push(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd25));
        press_cancel();
        tick();
        push(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
        reset = 1'b1;
        quarter_in = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        check_val("wr_reset_credit", credit, 8'd0);
        check_val("wr_reset_change", change, 8'd0);
        check_val("wr_reset_busy", {7'd0, busy}, 8'd0);
        tick(); tick(); tick();
        quarter_in = 1'b0;
        tick();
        push(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd25, 8'd0));
        quarter_in = 1'b1;
        tick();
        quarter_in = 1'b0;
        tick(); tick(); tick(); tick();

        // Every expected event must have been observed
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events got_remaining=%0d want=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
